// File: rtl/core_pipe_fetch_queue_pkg.sv
// Shared constants and types for the halfword fetch queue.
// Decode imports the same FQ_* constants so that both sides agree on
// the fetch width, queue capacity and drain window.
package core_pipe_fetch_queue_pkg;

    // Default geometry of the fetch queue
    localparam int FQ_FETCH_W   = 64;
    localparam int FQ_BUF_HW    = 6;
    localparam int FQ_DRAIN_MAX = 2;

    // Halfwords delivered by one full fetch beat
    localparam int FQ_FETCH_HW  = FQ_FETCH_W / 16;

    // Widths of the depth, fill-count and drain-count fields
    localparam int FQ_DEPTH_R   = $clog2(FQ_BUF_HW + 1);
    localparam int FQ_FCNT_R    = $clog2(FQ_FETCH_HW + 1);
    localparam int FQ_DCNT_R    = $clog2(FQ_DRAIN_MAX + 1);

    // Direction of a halfword barrel shift.
    // Down moves data towards slot 0 (older).
    // Up moves data towards higher slots.
    typedef enum logic {
        SHIFT_DOWN = 1'b0,
        SHIFT_UP   = 1'b1
    } shift_dir_e;

    // Bit width of n halfwords
    function automatic int hw_bits(input int n);
        return 16 * n;
    endfunction

endpackage

// File: rtl/core_pipe_fetch_queue_shift.sv
// Combinational halfword barrel shifter.
// Shifts a vector of NUM_HW halfwords by 'amount' halfwords in the
// direction DIR. Vacated halfwords are filled with zero.
// Amounts of NUM_HW or more produce an all-zero result.
module core_pipe_fetch_queue_shift
    import core_pipe_fetch_queue_pkg::*;
#(
    parameter int         NUM_HW = FQ_BUF_HW,
    parameter int         AMT_W  = FQ_DEPTH_R + 1,
    parameter shift_dir_e DIR    = SHIFT_DOWN
) (
    input  logic [hw_bits(NUM_HW)-1:0] data_in,
    input  logic [AMT_W-1:0]           amount,
    output logic [hw_bits(NUM_HW)-1:0] data_out
);

    // One logarithmic stage per amount bit; each stage shifts by 2**b halfwords
    always_comb begin
        data_out = data_in;
        for (int b = 0; b < AMT_W; b++) begin
            if (amount[b]) begin
                if (DIR == SHIFT_UP) begin
                    data_out = data_out << (16 * (2 ** b));
                end else begin
                    data_out = data_out >> (16 * (2 ** b));
                end
            end
        end
    end

endmodule

// File: rtl/core_pipe_fetch_queue.sv
// Halfword-granular fetch queue between the fetch bus and decode.
// Fills of up to FETCH_HW halfwords enter under a valid/ready handshake.
// Decode sees the oldest DRAIN_MAX halfwords and drains 0..DRAIN_MAX of
// them per cycle. Each stored halfword carries a fetch-error tag.
// Over-drain is clamped to the current depth and latched in drain_err.
module core_pipe_fetch_queue
    import core_pipe_fetch_queue_pkg::*;
#(
    parameter  int FETCH_W   = FQ_FETCH_W,
    parameter  int BUF_HW    = FQ_BUF_HW,
    parameter  int DRAIN_MAX = FQ_DRAIN_MAX,
    localparam int FETCH_HW  = FETCH_W / 16,
    localparam int DEPTH_W   = $clog2(BUF_HW + 1),
    localparam int FCNT_W    = $clog2(FETCH_HW + 1),
    localparam int DCNT_W    = $clog2(DRAIN_MAX + 1)
) (
    input  logic                   g_clk,
    input  logic                   g_resetn,
    input  logic                   flush,
    input  logic                   fill_valid,
    output logic                   fill_ready,
    input  logic [FETCH_W-1:0]     fill_data,
    input  logic [FCNT_W-1:0]      fill_count,
    input  logic                   fill_error,
    input  logic [DCNT_W-1:0]      drain_count,
    output logic [DEPTH_W-1:0]     depth,
    output logic [16*DRAIN_MAX-1:0] data_out,
    output logic [DRAIN_MAX-1:0]   error_out,
    output logic                   drain_err
);

    // One extra bit on all depth arithmetic so that subtraction and
    // comparison can never wrap around.
    localparam int DEPTH_X = DEPTH_W + 1;

    localparam logic [DEPTH_X-1:0] BUF_HW_X   = DEPTH_X'(BUF_HW);
    localparam logic [DEPTH_X-1:0] FETCH_HW_X = DEPTH_X'(FETCH_HW);

    // Queue storage; slot 0 is the oldest and unused slots are kept at zero
    logic [16*BUF_HW-1:0] data_q;
    logic [BUF_HW-1:0]    err_q;
    logic [DEPTH_X-1:0]   depth_q;
    logic                 drain_err_q;

    // Next-state intermediates
    logic [DEPTH_X-1:0]   drain_x;
    logic [DEPTH_X-1:0]   drain_eff;
    logic                 over_drain;
    logic                 fill_acc;
    logic [FCNT_W-1:0]    fill_cnt_eff;
    logic [DEPTH_X-1:0]   fill_base;
    logic [DEPTH_X-1:0]   depth_next;

    logic [16*BUF_HW-1:0] fill_ext;
    logic [BUF_HW-1:0]    fill_err_ext;
    logic [16*BUF_HW-1:0] data_drained;
    logic [16*BUF_HW-1:0] data_filled;
    logic [BUF_HW-1:0]    err_drained;
    logic [BUF_HW-1:0]    err_filled;

    // Space check uses only the registered depth, so a same-cycle drain
    // never opens the door for a fill.
    assign fill_ready = (BUF_HW_X - depth_q) >= FETCH_HW_X;

    // Handshake qualification and drain clamping
    assign fill_acc     = fill_valid && fill_ready && !flush;
    assign fill_cnt_eff = fill_acc ? fill_count : '0;
    assign drain_x      = DEPTH_X'(drain_count);
    assign over_drain   = drain_x > depth_q;
    assign drain_eff    = over_drain ? depth_q : drain_x;
    assign fill_base    = depth_q - drain_eff;
    assign depth_next   = fill_base + DEPTH_X'(fill_cnt_eff);

    // Keep only the accepted low halfwords of the fill beat, widened to queue size
    always_comb begin
        fill_ext     = '0;
        fill_err_ext = '0;
        for (int i = 0; i < FETCH_HW; i++) begin
            if (i < int'(fill_cnt_eff)) begin
                fill_ext[16*i +: 16] = fill_data[16*i +: 16];
                fill_err_ext[i]      = fill_error;
            end
        end
    end

    // Drain: existing contents slide towards slot 0 by the effective drain
    core_pipe_fetch_queue_shift #(
        .NUM_HW (BUF_HW),
        .AMT_W  (DEPTH_X),
        .DIR    (SHIFT_DOWN)
    ) u_drain_shift (
        .data_in  (data_q),
        .amount   (drain_eff),
        .data_out (data_drained)
    );

    // Fill: new halfwords land just above the surviving contents
    core_pipe_fetch_queue_shift #(
        .NUM_HW (BUF_HW),
        .AMT_W  (DEPTH_X),
        .DIR    (SHIFT_UP)
    ) u_fill_shift (
        .data_in  (fill_ext),
        .amount   (fill_base),
        .data_out (data_filled)
    );

    // Error tags follow the same movement as their halfwords
    assign err_drained = err_q >> drain_eff;
    assign err_filled  = fill_err_ext << fill_base;

    // State update: reset beats flush, flush beats fill and drain.
    // OR-merging is safe because vacated and unused slots are always zero.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            data_q      <= '0;
            err_q       <= '0;
            depth_q     <= '0;
            drain_err_q <= 1'b0;
        end else if (flush) begin
            data_q      <= '0;
            err_q       <= '0;
            depth_q     <= '0;
            drain_err_q <= 1'b0;
        end else begin
            data_q      <= data_drained | data_filled;
            err_q       <= err_drained | err_filled;
            depth_q     <= depth_next;
            drain_err_q <= drain_err_q | over_drain;
        end
    end

    // Decode window and status are direct views of the registers
    assign depth     = depth_q[DEPTH_W-1:0];
    assign data_out  = data_q[16*DRAIN_MAX-1:0];
    assign error_out = err_q[DRAIN_MAX-1:0];
    assign drain_err = drain_err_q;

endmodule

// File: tb/tb_core_pipe_fetch_queue.sv
// Testbench for core_pipe_fetch_queue at default geometry
// (FETCH_W=64, BUF_HW=6, DRAIN_MAX=2).
// The reference is a queue of {error, halfword} entries updated with the
// plain queue rules: flush empties, drain pops min(drain, size) from the
// front, an accepted fill pushes fill_count halfwords on the back.
module tb_core_pipe_fetch_queue;

    localparam int BUF_HW    = 6;
    localparam int FETCH_HW  = 4;
    localparam int DRAIN_MAX = 2;

    logic        g_clk;
    logic        g_resetn;
    logic        flush;
    logic        fill_valid;
    logic        fill_ready;
    logic [63:0] fill_data;
    logic [2:0]  fill_count;
    logic        fill_error;
    logic [1:0]  drain_count;
    logic [2:0]  depth;
    logic [31:0] data_out;
    logic [1:0]  error_out;
    logic        drain_err;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [16:0] mq[$];
    bit          m_derr;

    core_pipe_fetch_queue dut (
        .g_clk       (g_clk),
        .g_resetn    (g_resetn),
        .flush       (flush),
        .fill_valid  (fill_valid),
        .fill_ready  (fill_ready),
        .fill_data   (fill_data),
        .fill_count  (fill_count),
        .fill_error  (fill_error),
        .drain_count (drain_count),
        .depth       (depth),
        .data_out    (data_out),
        .error_out   (error_out),
        .drain_err   (drain_err)
    );

    // Free-running clock
    initial begin
        g_clk = 1'b0;
        forever #5 g_clk = ~g_clk;
    end

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit modelReady();
        return (BUF_HW - mq.size()) >= FETCH_HW;
    endfunction

    // Compare every DUT output against the model (called at negedge)
    task automatic checkOutput(input string tag);
        logic [31:0] exp_data;
        logic [1:0]  exp_err;
        exp_data = '0;
        exp_err  = '0;
        for (int i = 0; i < DRAIN_MAX; i++) begin
            if (i < mq.size()) begin
                exp_data[16*i +: 16] = mq[i][15:0];
                exp_err[i]           = mq[i][16];
            end
        end
        checkVal({tag, ".depth"},      64'(depth),      64'(mq.size()));
        checkVal({tag, ".data_out"},   64'(data_out),   64'(exp_data));
        checkVal({tag, ".error_out"},  64'(error_out),  64'(exp_err));
        checkVal({tag, ".fill_ready"}, 64'(fill_ready), 64'(modelReady()));
        checkVal({tag, ".drain_err"},  64'(drain_err),  64'(m_derr));
    endtask

    // Drive one cycle of inputs at negedge, advance one clock, update the model
    task automatic applyStimulus(input bit f, input bit v, input logic [63:0] dat,
                                 input int cnt, input bit e, input int dr);
        bit rdy;
        int d;
        flush       = f;
        fill_valid  = v;
        fill_data   = dat;
        fill_count  = 3'(cnt);
        fill_error  = e;
        drain_count = 2'(dr);
        rdy = modelReady();
        @(posedge g_clk);
        if (f) begin
            mq.delete();
            m_derr = 1'b0;
        end else begin
            d = (dr > mq.size()) ? mq.size() : dr;
            if (dr > mq.size()) m_derr = 1'b1;
            repeat (d) void'(mq.pop_front());
            if (v && rdy) begin
                for (int i = 0; i < cnt; i++) mq.push_back({e, dat[16*i +: 16]});
            end
        end
        @(negedge g_clk);
    endtask

    task automatic applyReset(input int cycles);
        g_resetn    = 1'b0;
        flush       = 1'b1;
        fill_valid  = 1'b1;
        fill_data   = {$urandom, $urandom};
        fill_count  = 3'd4;
        fill_error  = 1'b1;
        drain_count = 2'd1;
        repeat (cycles) @(posedge g_clk);
        mq.delete();
        m_derr = 1'b0;
        @(negedge g_clk);
        g_resetn = 1'b1;
        flush    = 1'b0;
        fill_valid = 1'b0;
        drain_count = 2'd0;
    endtask

    initial begin
        g_resetn    = 1'b0;
        flush       = 1'b0;
        fill_valid  = 1'b0;
        fill_data   = '0;
        fill_count  = '0;
        fill_error  = 1'b0;
        drain_count = '0;
        m_derr      = 1'b0;

        // 1. reset held two cycles
        applyReset(2);
        checkOutput("reset");
        checkVal("reset.data_out_const", 64'(data_out), 64'h0);
        checkVal("reset.ready_const", 64'(fill_ready), 64'h1);

        // 2. full fill, then drain two
        applyStimulus(0, 1, 64'h4444_3333_2222_1111, 4, 0, 0);
        checkOutput("fill4");
        checkVal("fill4.data_const", 64'(data_out), 64'h2222_1111);
        checkVal("fill4.ready_const", 64'(fill_ready), 64'h0);
        applyStimulus(0, 0, 64'h0, 0, 0, 2);
        checkOutput("drain2");
        checkVal("drain2.data_const", 64'(data_out), 64'h4444_3333);

        // 3. refused fill at depth 4, then fill with simultaneous drain
        applyStimulus(0, 1, 64'h0000_0000_DDDD_CCCC, 2, 0, 0);
        checkOutput("fill2");
        applyStimulus(0, 1, 64'h9999_9999_9999_9999, 4, 1, 0);
        checkOutput("refused");
        checkVal("refused.depth_const", 64'(depth), 64'd4);
        applyStimulus(0, 0, 64'h0, 0, 0, 2);
        checkOutput("drain_to2");
        applyStimulus(0, 1, 64'h8888_7777_6666_5555, 4, 0, 2);
        checkOutput("fill_drain");
        checkVal("fill_drain.data_const", 64'(data_out), 64'h6666_5555);

        // 4. per-halfword error tag
        applyStimulus(1, 0, 64'h0, 0, 0, 0);
        applyStimulus(0, 1, 64'h1111, 1, 0, 0);
        applyStimulus(0, 1, 64'h2222, 1, 1, 0);
        checkOutput("errtag");
        checkVal("errtag.err_const", 64'(error_out), 64'b10);

        // 5. flush beats fill and drain
        applyStimulus(0, 1, 64'h3333, 1, 0, 0);
        applyStimulus(1, 1, 64'hFFFF_EEEE_DDDD_CCCC, 4, 0, 2);
        checkOutput("flush");
        checkVal("flush.depth_const", 64'(depth), 64'd0);

        // 6. over-drain clamps and sets the sticky flag
        applyStimulus(0, 1, 64'h5A5A, 1, 0, 0);
        applyStimulus(0, 0, 64'h0, 0, 0, 2);
        checkOutput("overdrain");
        checkVal("overdrain.flag_const", 64'(drain_err), 64'h1);
        applyStimulus(0, 1, 64'h0000_0000_0000_1234, 1, 0, 0);
        checkOutput("sticky");
        applyStimulus(1, 0, 64'h0, 0, 0, 0);
        checkOutput("flush_clears");

        // Randomised traffic with occasional flush and reset
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                applyReset(1);
                checkOutput("rnd_reset");
            end else begin
                applyStimulus($urandom_range(0, 24) == 0, 1'($urandom),
                              {$urandom, $urandom}, $urandom_range(0, 4),
                              1'($urandom), $urandom_range(0, 2));
                checkOutput("rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/core_pipe_fetch_queue.md
Name: core_pipe_fetch_queue

Overview:
Parametrised halfword-granular fetch queue between the fetch bus interface and the decode stage. It accepts 0..FETCH_HW halfwords per cycle under a valid/ready handshake and presents the oldest DRAIN_MAX halfwords to decode. Decode drains 0..DRAIN_MAX halfwords per cycle. Each stored halfword carries a fetch-error tag. Compared with the fixed 96-bit buffer, this block adds configurable widths and capacity, explicit backpressure, and protection against over-drain.

Parameters:
FETCH_W, 64, fill data width in bits; multiple of 16; FETCH_HW = FETCH_W/16.
BUF_HW, 6, queue capacity in halfwords; must be >= FETCH_HW and >= DRAIN_MAX.
DRAIN_MAX, 2, maximum halfwords drained per cycle; width of the data_out window.

Ports:
g_clk  in  1  global clock
g_resetn  in  1  global reset, synchronous, active-low
flush  in  1  discard all queue contents
fill_valid  in  1  fill request
fill_ready  out  1  queue can accept a full FETCH_HW fill this cycle
fill_data  in  FETCH_W  fill data; lowest halfword is the oldest
fill_count  in  clog2(FETCH_HW+1)  number of low halfwords of fill_data to load
fill_error  in  1  tag every loaded halfword with a fetch error
drain_count  in  clog2(DRAIN_MAX+1)  halfwords consumed by decode this cycle
depth  out  clog2(BUF_HW+1)  occupied halfwords (registered)
data_out  out  16*DRAIN_MAX  oldest halfwords; bits [15:0] are the oldest
error_out  out  DRAIN_MAX  per-halfword error tags aligned with data_out
drain_err  out  1  registered sticky flag: an over-drain was clamped

Behaviour:
- Storage: BUF_HW x 16-bit data array plus BUF_HW x 1-bit error array. Slot 0 is the oldest. All slots at index >= depth hold zero.
- Reset (g_resetn=0 at a clock edge):
  - depth=0, all slots 0, drain_err=0.
  - Outputs after reset: data_out=0, error_out=0, fill_ready=1.
- fill_ready is combinational from the registered depth: fill_ready = (BUF_HW - depth) >= FETCH_HW. It does not depend on same-cycle drain_count. It has no combinational path from any input.
- Accepted fill: acc = fill_valid && fill_ready && !flush. When acc=0, fill_count is treated as 0.
- Effective drain: d = min(drain_count, depth).
  - If drain_count > depth, the drain is clamped to d and drain_err is set.
  - drain_err clears only on reset or flush.
- Per-cycle update (single clock edge; drain is applied before fill):
  - Shift the existing contents down by d halfwords and zero-fill from the top.
  - Write fill halfwords 0..fill_count-1 into slots (depth-d)..(depth-d+fill_count-1).
  - Each written slot gets its error tag set to fill_error.
  - depth_next = depth - d + fill_count.
  - Because fill_ready guarantees space before drain, overflow is impossible.
- fill_count = 0 with fill_valid=1 is legal and acts as a no-op handshake.
- Latency: filled data is visible on data_out the cycle after acceptance. There is no bypass from fill_data to data_out.
- data_out and error_out are pure slices of slots 0..DRAIN_MAX-1, i.e. registered.
- flush has priority over fill and drain: next cycle depth=0, all slots 0, drain_err=0. A fill presented in the flush cycle is discarded.
- Reset has priority over flush.
- Simultaneous fill and drain at full occupancy: drain never changes fill_ready within the same cycle. The next cycle's fill_ready reflects the new depth.
- Arithmetic: depth math uses clog2(BUF_HW+1)+1 bits internally to avoid wrap. Shift amounts are in halfwords (16*n bits).

Decomposition:
- core_common.vh gains the following constants, shared with decode:
  - FQ_FETCH_W, FQ_BUF_HW, FQ_DRAIN_MAX
  - derived ranges FQ_DEPTH_R, FQ_FCNT_R, FQ_DCNT_R
- One sub-module, core_pipe_fetch_queue_shift: a combinational halfword barrel shifter (left or right by n halfwords, parametrised width and maximum shift). It is instantiated twice: drain shift-down and fill shift-up.
- Merging of the shifted fill and the shifted existing contents is a bitwise OR. This is valid because empty slots are held at zero.

Test Plan (defaults FETCH_W=64, BUF_HW=6, DRAIN_MAX=2):
1. Reset held 2 cycles then released -> depth=0, fill_ready=1, data_out=0, error_out=0, drain_err=0.
2. Fill count=4, data=0x4444_3333_2222_1111, error=0 -> next cycle depth=4, data_out=0x2222_1111, fill_ready=0. Then drain 2 -> depth=2, data_out=0x4444_3333, fill_ready=1.
3. At depth=4, fill_valid=1 with count=4 -> not accepted, depth stays 4. At depth=2 (0xBBBB_AAAA), fill 4 halfwords 0x8888_7777_6666_5555 plus drain 2 -> depth=4, data_out=0x6666_5555.
4. At depth=1 (0x1111, err 0), fill count=1, data 0x2222, fill_error=1 -> depth=2, data_out=0x2222_1111, error_out=2'b10.
5. At depth=3, flush plus fill count=4 plus drain 2 in the same cycle -> depth=0, data_out=0, fill_ready=1. The fill data never appears.
6. At depth=1, drain_count=2 -> depth=0, drain_err=1 held until flush, data_out=0. Depth never wraps.
